// File: rtl/csr_counter_file.sv
// Machine/user counter CSR file: mcycle, minstret and NUM_EVT mhpmcounters with CSRRW/RS/RC read-modify-write.
// Optional mcountinhibit register at 0x320 is built when CSR_COUNTINHIBIT_EN is defined.
module csr_counter_file #(
    parameter int CNT_WIDTH = 64,
    parameter int NUM_EVT   = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                csr_en,
    input  logic [2:0]                          csr_funct3,
    input  logic [11:0]                         csr_addr,
    input  logic [4:0]                          csr_rs1_idx,
    input  logic [31:0]                         csr_wdata,
    input  logic                                retire,
    input  logic [(NUM_EVT > 0 ? NUM_EVT : 1)-1:0] evt,
    output logic [31:0]                         csr_rdata,
    output logic                                csr_hit,
    output logic                                csr_illegal
);

    localparam int NUM_CNT = 3 + NUM_EVT;

    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
    logic [NUM_CNT-1:0]   inh;
    logic [NUM_CNT-1:0]   cnt_sel;
    logic [NUM_CNT-1:0]   inc_vec;

    logic        region_m;
    logic        region_u;
    logic        hi_half;
    logic [4:0]  off;
    logic        cnt_hit;
    logic        inh_hit;
    logic        f3_valid;
    logic        wr_att;
    logic        do_wr;
    logic [31:0] operand;
    logic [31:0] new_val;
    logic [63:0] rd64;

    assign off      = csr_addr[4:0];
    assign hi_half  = csr_addr[7];
    assign region_m = (csr_addr[11:8] == 4'hB) && (csr_addr[6:5] == 2'b00);
    assign region_u = (csr_addr[11:8] == 4'hC) && (csr_addr[6:5] == 2'b00);

    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (i != 1) begin
                cnt_sel[i] = (region_m || region_u) && (off == 5'(i));
            end
        end
    end

    assign cnt_hit = |cnt_sel;

`ifdef CSR_COUNTINHIBIT_EN
    localparam logic [NUM_CNT-1:0] INH_MASK = ~NUM_CNT'(2);
    logic [NUM_CNT-1:0] inh_q;
    logic [NUM_CNT-1:0] inh_d;

    assign inh_hit = (csr_addr == 12'h320);
    assign inh     = inh_q;

    always_comb begin
        inh_d = inh_q;
        if (do_wr && inh_hit) begin
            inh_d = new_val[NUM_CNT-1:0] & INH_MASK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inh_q <= '0;
        end else begin
            inh_q <= inh_d;
        end
    end
`else
    assign inh_hit = 1'b0;
    assign inh     = '0;
`endif

    assign csr_hit = cnt_hit | inh_hit;

    always_comb begin
        rd64 = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (cnt_sel[i]) begin
                rd64 = 64'(cnt_q[i]);
            end
        end
        csr_rdata = hi_half ? rd64[63:32] : rd64[31:0];
        if (inh_hit) begin
            csr_rdata = 32'(inh);
        end
    end

    // funct3 values x00 are not CSR operations.
    assign f3_valid = (csr_funct3[1:0] != 2'b00);
    assign operand  = csr_funct3[2] ? {27'b0, csr_rs1_idx} : csr_wdata;
    assign wr_att   = (csr_funct3[1:0] == 2'b01) || (csr_rs1_idx != 5'd0);

    always_comb begin
        case (csr_funct3[1:0])
            2'b10:   new_val = csr_rdata | operand;
            2'b11:   new_val = csr_rdata & ~operand;
            default: new_val = operand;
        endcase
    end

    assign csr_illegal = csr_en && f3_valid &&
                         (!csr_hit || (wr_att && (csr_addr[11:10] == 2'b11)));
    assign do_wr       = csr_en && f3_valid && wr_att && csr_hit && !csr_illegal;

    always_comb begin
        inc_vec    = '0;
        inc_vec[0] = 1'b1;
        inc_vec[2] = retire;
        for (int k = 0; k < NUM_EVT; k++) begin
            inc_vec[3+k] = evt[k];
        end
    end

    // A write to either half wins over that counter's increment, so no carry crosses halves.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i == 1) begin
                cnt_d[i] = '0;
            end else if (do_wr && cnt_sel[i]) begin
                if (hi_half) begin
                    cnt_d[i] = CNT_WIDTH'({new_val, cnt_q[i][31:0]});
                end else begin
                    cnt_d[i] = {cnt_q[i][CNT_WIDTH-1:32], new_val};
                end
            end else if (inc_vec[i] && !inh[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
